// File: rtl/aes_cmd_issuer_pkg.sv
// Shared AES datapath sizes and block-formatting helpers for the command issuer.
package aes_cmd_issuer_pkg;

  localparam int BLK_S  = 128;
  localparam int KEY_S  = 256;
  localparam int WORD_S = 32;

  function automatic logic [BLK_S-1:0] cmd_block(input logic [WORD_S-1:0] cmd);
    return {{(BLK_S-WORD_S){1'b0}}, cmd};
  endfunction

endpackage

// File: rtl/aes_cmd_issuer_if.sv
// AXI-Stream beat channel from the issuer toward the aes_controller input.
interface aes_cmd_issuer_if #(
  parameter int DW = 32
) ();

  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/aes_blk_serializer.sv
// Holds one 128-bit block and shifts it out as 32-bit AXI-Stream beats, low word first.
module aes_blk_serializer
  import aes_cmd_issuer_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [BLK_S-1:0] load_data,
  input  logic             load_last,
  output logic             load_ok,
  output logic             block_done,
  output logic             pkt_done,
  aes_cmd_issuer_if.master m
);

  localparam logic [1:0] LAST_BEAT = 2'(BLK_S / BUS_DATA_WIDTH - 1);

  logic [BLK_S-1:0] shreg_q, shreg_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             last_q, last_d;
  logic             beat_acc_s;

  assign beat_acc_s = held_q && m.tready;
  assign block_done = beat_acc_s && (cnt_q == LAST_BEAT);
  assign pkt_done   = block_done && last_q;
  // A packet's final block is never followed by a reload in the same cycle.
  assign load_ok    = !held_q || (block_done && !last_q);

  assign m.tvalid = held_q;
  assign m.tdata  = shreg_q[BUS_DATA_WIDTH-1:0];
  assign m.tlast  = held_q && last_q && (cnt_q == LAST_BEAT);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    last_d  = last_q;
    if (load_valid && load_ok) begin
      shreg_d = load_data;
      cnt_d   = 2'd0;
      held_d  = 1'b1;
      last_d  = load_last;
    end else if (beat_acc_s) begin
      shreg_d = shreg_q >> BUS_DATA_WIDTH;
      cnt_d   = cnt_q + 2'd1;
      if (cnt_q == LAST_BEAT) begin
        held_d = 1'b0;
        last_d = 1'b0;
      end else begin
        held_d = 1'b1;
      end
    end else begin
      held_d = held_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= {BLK_S{1'b0}};
      cnt_q   <= 2'd0;
      held_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/aes_cmd_issuer.sv
// Sequences CMD, key, optional IV and payload blocks of one AES packet onto the stream.
// Optional AES-256 upper key half is enabled by defining AES_ISSUER_AES256_EN.
module aes_cmd_issuer
  import aes_cmd_issuer_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_S-1:0] req_cmd,
  input  logic [KEY_S-1:0]  req_key,
  input  logic [BLK_S-1:0]  req_iv,
  input  logic              req_key256,
  input  logic              req_need_iv,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic [BLK_S-1:0]  blk_data,
  input  logic              blk_last,
  aes_cmd_issuer_if.master  m,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_KEY_LO = 3'd2,
    ST_KEY_HI = 3'd3,
    ST_IV     = 3'd4,
    ST_DATA   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [BLK_S-1:0] key_lo_q, key_lo_d;
  logic [BLK_S-1:0] iv_q, iv_d;
  logic             need_iv_q, need_iv_d;
  logic [BLK_S-1:0] key_hi_s;
  logic             hi_en_s;

  logic             load_valid_s;
  logic [BLK_S-1:0] load_data_s;
  logic             load_last_s;
  logic             load_ok_s;
  logic             block_done_s;
  logic             pkt_done_s;

`ifdef AES_ISSUER_AES256_EN
  logic [BLK_S-1:0] key_hi_q, key_hi_d;
  logic             key256_q, key256_d;
  assign key_hi_s = key_hi_q;
  assign hi_en_s  = key256_q;
`else
  logic unused_key_hi_s;
  assign unused_key_hi_s = ^{req_key[KEY_S-1:BLK_S], req_key256};
  assign key_hi_s = {BLK_S{1'b0}};
  assign hi_en_s  = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign blk_ready = (state_q == ST_DATA) && load_ok_s;

  // The CMD block goes straight into the serializer on acceptance, so the command word needs no copy here.
  always_comb begin
    state_d      = state_q;
    key_lo_d     = key_lo_q;
    iv_d         = iv_q;
    need_iv_d    = need_iv_q;
`ifdef AES_ISSUER_AES256_EN
    key_hi_d     = key_hi_q;
    key256_d     = key256_q;
`endif
    load_valid_s = 1'b0;
    load_data_s  = {BLK_S{1'b0}};
    load_last_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d      = ST_CMD;
          key_lo_d     = req_key[BLK_S-1:0];
          iv_d         = req_iv;
          need_iv_d    = req_need_iv;
`ifdef AES_ISSUER_AES256_EN
          key_hi_d     = req_key[KEY_S-1:BLK_S];
          key256_d     = req_key256;
`endif
          load_valid_s = 1'b1;
          load_data_s  = cmd_block(req_cmd);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (block_done_s) begin
          state_d      = ST_KEY_LO;
          load_valid_s = 1'b1;
          load_data_s  = key_lo_q;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_KEY_LO: begin
        if (block_done_s && hi_en_s) begin
          state_d      = ST_KEY_HI;
          load_valid_s = 1'b1;
          load_data_s  = key_hi_s;
        end else if (block_done_s && need_iv_q) begin
          state_d      = ST_IV;
          load_valid_s = 1'b1;
          load_data_s  = iv_q;
        end else if (block_done_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_KEY_LO;
        end
      end
      ST_KEY_HI: begin
        if (block_done_s && need_iv_q) begin
          state_d      = ST_IV;
          load_valid_s = 1'b1;
          load_data_s  = iv_q;
        end else if (block_done_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_KEY_HI;
        end
      end
      ST_IV: begin
        if (block_done_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_IV;
        end
      end
      ST_DATA: begin
        if (blk_valid && load_ok_s) begin
          load_valid_s = 1'b1;
          load_data_s  = blk_data;
          load_last_s  = blk_last;
        end else begin
          load_valid_s = 1'b0;
        end
        if (pkt_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      key_lo_q  <= {BLK_S{1'b0}};
      iv_q      <= {BLK_S{1'b0}};
      need_iv_q <= 1'b0;
`ifdef AES_ISSUER_AES256_EN
      key_hi_q  <= {BLK_S{1'b0}};
      key256_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      key_lo_q  <= key_lo_d;
      iv_q      <= iv_d;
      need_iv_q <= need_iv_d;
`ifdef AES_ISSUER_AES256_EN
      key_hi_q  <= key_hi_d;
      key256_q  <= key256_d;
`endif
    end
  end

  aes_blk_serializer #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid_s),
    .load_data (load_data_s),
    .load_last (load_last_s),
    .load_ok   (load_ok_s),
    .block_done(block_done_s),
    .pkt_done  (pkt_done_s),
    .m         (m)
  );

endmodule

// File: tb/tb_aes_cmd_issuer.sv
// Randomized bench for aes_cmd_issuer against a packet-level expected-beat queue.
module tb_aes_cmd_issuer;
  import aes_cmd_issuer_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_cmd;
  logic [255:0]     req_key;
  logic [127:0]     req_iv;
  logic             req_key256;
  logic             req_need_iv;
  logic             blk_valid;
  logic             blk_ready;
  logic [127:0]     blk_data;
  logic             blk_last;
  logic             busy;

  aes_cmd_issuer_if #(.DW(32)) m_if ();

  aes_cmd_issuer #(.BUS_DATA_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_key    (req_key),
    .req_iv     (req_iv),
    .req_key256 (req_key256),
    .req_need_iv(req_need_iv),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_last   (blk_last),
    .m          (m_if),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_data[$];
  bit          exp_last[$];
  logic [31:0] cap_q[$];
  int          acc_cnt  = 0;
  int          rdy_mode = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expected beats of one 128-bit block: low word first, tlast only on the final word of the last block.
  task automatic push_block(input logic [127:0] b, input bit last);
    for (int i = 0; i < 4; i++) begin
      exp_data.push_back(b[32*i +: 32]);
      exp_last.push_back(last && (i == 3));
    end
  endtask

  // tready generator: always ready, random, or the repeating 1,0,0,1 pattern.
  initial begin
    bit pat[4];
    int pidx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    pidx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: m_if.tready = 1'($urandom_range(0, 1));
        2: begin
          m_if.tready = pat[pidx];
          pidx = (pidx + 1) % 4;
        end
        default: m_if.tready = 1'b1;
      endcase
    end
  end

  // Output monitor: beat order/content, stall stability, and no valid beat without an expected one.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    prev_stall = 1'b0;
    prev_d = 32'h0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_valid", m_if.tvalid, 1'b1);
          check_eq("stall_data", m_if.tdata, prev_d);
          check_eq("stall_last", m_if.tlast, prev_l);
        end
        if (m_if.tvalid && m_if.tready) begin
          if (exp_data.size() == 0) begin
            check_eq("extra_beat", m_if.tvalid, 1'b0);
          end else begin
            check_eq("beat_data", m_if.tdata, exp_data.pop_front());
            check_eq("beat_last", m_if.tlast, exp_last.pop_front());
          end
          cap_q.push_back(m_if.tdata);
          acc_cnt++;
        end else if (exp_data.size() == 0) begin
          check_eq("idle_valid", m_if.tvalid, 1'b0);
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_d = m_if.tdata;
        prev_l = m_if.tlast;
      end
    end
  end

  task automatic start_request(input logic [31:0] cmd, input logic [255:0] key, input logic [127:0] iv,
                               input bit k256, input bit niv);
    bit ok;
    ok = 1'b0;
    req_cmd = cmd; req_key = key; req_iv = iv; req_key256 = k256; req_need_iv = niv;
    req_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("req_accept", ok, 1'b1);
    push_block({96'h0, cmd}, 1'b0);
    push_block(key[127:0], 1'b0);
`ifdef AES_ISSUER_AES256_EN
    if (k256) push_block(key[255:128], 1'b0);
`endif
    if (niv) push_block(iv, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd = $urandom(); req_key = {rand128(), rand128()}; req_iv = rand128();
    req_key256 = 1'($urandom_range(0, 1)); req_need_iv = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("first_valid", m_if.tvalid, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_packet(input logic [31:0] cmd, input logic [255:0] key, input logic [127:0] iv,
                            input bit k256, input bit niv, input int nblk, input int gap_after,
                            input logic [127:0] first_blk);
    int start_acc;
    int exp_beats;
    int g;
    bit ok;
    logic [127:0] blk;
    cap_q.delete();
    start_acc = acc_cnt;
    exp_beats = 4 * (2 + (niv ? 1 : 0) + nblk);
`ifdef AES_ISSUER_AES256_EN
    if (k256) exp_beats += 4;
`endif
    start_request(cmd, key, iv, k256, niv);
    for (int b = 0; b < nblk; b++) begin
      blk = (b == 0) ? first_blk : rand128();
      blk_valid = 1'b1; blk_data = blk; blk_last = (b == nblk - 1);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (blk_ready) begin
          ok = 1'b1;
          break;
        end
      end
      check_eq("blk_accept", ok, 1'b1);
      if (ok) push_block(blk, b == nblk - 1);
      @(posedge clk);
      #1;
      blk_valid = 1'b0; blk_data = rand128(); blk_last = 1'($urandom_range(0, 1));
      g = (b == gap_after) ? 8 : int'($urandom_range(0, 2));
      for (int i = 0; i < g; i++) begin
        @(negedge clk);
        if (b == gap_after && i == g - 1) begin
          check_eq("gap_valid", m_if.tvalid, 1'b0);
          check_eq("gap_last", m_if.tlast, 1'b0);
          check_eq("gap_busy", busy, 1'b1);
        end
        @(posedge clk);
        #1;
      end
    end
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_data.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("pkt_done", ok, 1'b1);
    check_eq("beat_count", 128'(acc_cnt - start_acc), 128'(exp_beats));
    check_eq("end_req_ready", req_ready, 1'b1);
    check_eq("end_valid", m_if.tvalid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] key;
    logic [127:0] iv;
    logic [127:0] hi_exp;
    bit ok;
    int start;
    reset = 1'b1; req_valid = 1'b0; req_cmd = 32'h0; req_key = 256'h0; req_iv = 128'h0;
    req_key256 = 1'b0; req_need_iv = 1'b0; blk_valid = 1'b0; blk_data = 128'h0; blk_last = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", m_if.tvalid, 1'b0);
    check_eq("rst_tlast", m_if.tlast, 1'b0);
    check_eq("rst_tdata", m_if.tdata, 32'h0);
    check_eq("rst_blk_ready", blk_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req_ready", req_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ECB-128, single block, always ready.
    rdy_mode = 0;
    run_packet(32'h0000_0011, {rand128(), rand128()}, rand128(), 1'b0, 1'b0, 1, -1,
               128'h00112233_44556677_8899aabb_ccddeeff);
    check_eq("ecb_beat9", (cap_q.size() > 8) ? cap_q[8] : 32'h0, 32'hccddeeff);

    // Upper key half plus IV, two blocks.
    key = {rand128(), rand128()};
    iv = rand128();
`ifdef AES_ISSUER_AES256_EN
    hi_exp = key[255:128];
`else
    hi_exp = iv;
`endif
    run_packet($urandom(), key, iv, 1'b1, 1'b1, 2, -1, rand128());
    for (int i = 0; i < 4; i++) begin
      check_eq("hi_beat", (cap_q.size() > 8 + i) ? cap_q[8 + i] : 32'h0, hi_exp[32*i +: 32]);
    end

    // Repeating ready pattern 1,0,0,1.
    rdy_mode = 2;
    run_packet($urandom(), {rand128(), rand128()}, rand128(), 1'b1, 1'b1, 3, -1, rand128());

    // Payload gap inside DATA.
    rdy_mode = 0;
    run_packet($urandom(), {rand128(), rand128()}, rand128(), 1'b0, 1'b1, 3, 0, rand128());

    // Reset while the 6th beat is on the bus, then a clean packet.
    start_request($urandom(), {rand128(), rand128()}, rand128(), 1'b0, 1'b0);
    start = acc_cnt;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      if (acc_cnt - start >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("reach_beat6", ok, 1'b1);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_tvalid", m_if.tvalid, 1'b0);
    check_eq("abort_tlast", m_if.tlast, 1'b0);
    check_eq("abort_req_ready", req_ready, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    exp_data.delete();
    exp_last.delete();
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_packet($urandom(), {rand128(), rand128()}, rand128(), 1'b0, 1'b1, 2, -1, rand128());

    // Randomized packets.
    for (int p = 0; p < 15; p++) begin
      rdy_mode = int'($urandom_range(0, 2));
      run_packet($urandom(), {rand128(), rand128()}, rand128(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), -1, rand128());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
